// File: rtl/dma_pkg.sv
// Shared types and default sizing for the DMA burst engine and its address/count unit.
package dma_pkg;

  localparam int DMA_AW        = 16;
  localparam int DMA_DW        = 8;
  localparam int DMA_CW        = 8;
  localparam int DMA_TO_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } dma_state_e;

  function automatic logic is_bus_state(input dma_state_e s);
    return (s == ST_RD) || (s == ST_WR);
  endfunction

endpackage

// File: rtl/dma_addr_cnt.sv
// Source/destination address incrementers and remaining-word down-counter.
// Addresses wrap silently modulo 2^AW.
module dma_addr_cnt
  import dma_pkg::*;
#(
  parameter int AW = DMA_AW,
  parameter int CW = DMA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dst_in,
  input  logic [CW-1:0] cnt_in,
  input  logic          step,
  output logic [AW-1:0] src_r,
  output logic [AW-1:0] dst_r,
  output logic [CW-1:0] rem_r
);

  // Load has priority; step advances both addresses and consumes one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_r <= {AW{1'b0}};
      dst_r <= {AW{1'b0}};
      rem_r <= {CW{1'b0}};
    end else if (load) begin
      src_r <= src_in;
      dst_r <= dst_in;
      rem_r <= cnt_in;
    end else if (step) begin
      src_r <= src_r + AW'(1);
      dst_r <= dst_r + AW'(1);
      rem_r <= rem_r - CW'(1);
    end
  end

endmodule

// File: rtl/dma_burst_engine.sv
// DMA datapath engine: read/write word pairs over a return-to-zero req/ack bus.
// Define DMA_TIMEOUT_EN to add an ack watchdog that ends the transfer with err.
module dma_burst_engine
  import dma_pkg::*;
#(
  parameter int AW        = DMA_AW,
  parameter int DW        = DMA_DW,
  parameter int CW        = DMA_CW,
  parameter int TO_CYCLES = DMA_TO_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dst_in,
  input  logic [CW-1:0] cnt_in,
  input  logic          start,
  input  logic          abort,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] remaining
);

  if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_to_range
    $error("dma_burst_engine: TO_CYCLES must be within 1..255");
  end

  dma_state_e    state_r, next_state_s;
  logic [AW-1:0] src_r, dst_r, src_eff_s;
  logic [CW-1:0] rem_r, cnt_eff_s;
  logic [DW-1:0] buf_r;
  logic          to_wr_r;
  logic          load_s, start_s, rd_ack_s, wr_ack_s, fault_s, timeout_s;
  logic          bus_req_r, bus_we_r, busy_r, done_r, err_r;
  logic [AW-1:0] bus_addr_r;
  logic [DW-1:0] bus_wdata_r;

  dma_addr_cnt #(.AW(AW), .CW(CW)) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .src_in (src_in),
    .dst_in (dst_in),
    .cnt_in (cnt_in),
    .step   (wr_ack_s),
    .src_r  (src_r),
    .dst_r  (dst_r),
    .rem_r  (rem_r)
  );

`ifdef DMA_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] wd_r;

  // Watchdog: restarts on every entry to RD/WR, counts request cycles without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= 8'd0;
    end else if (is_bus_state(state_r) && (next_state_s == state_r)) begin
      wd_r <= wd_r + 8'd1;
    end else begin
      wd_r <= 8'd0;
    end
  end

  assign timeout_s = is_bus_state(state_r) && !bus_ack && (wd_r == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and per-state handshake decode.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    start_s      = 1'b0;
    rd_ack_s     = 1'b0;
    wr_ack_s     = 1'b0;
    fault_s      = 1'b0;
    cnt_eff_s    = rem_r;
    src_eff_s    = src_r;
    case (state_r)
      ST_IDLE: begin
        load_s  = load;
        start_s = start;
        // A simultaneous load feeds the start decision directly.
        if (load) begin
          cnt_eff_s = cnt_in;
          src_eff_s = src_in;
        end else begin
          cnt_eff_s = rem_r;
          src_eff_s = src_r;
        end
        if (start) begin
          if (cnt_eff_s != {CW{1'b0}}) begin
            next_state_s = ST_RD;
          end else begin
            next_state_s = ST_FIN;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        rd_ack_s = bus_ack & bus_req_r;
        fault_s  = abort | timeout_s;
        if (fault_s) begin
          next_state_s = ST_FIN;
        end else if (rd_ack_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_RD;
        end
      end
      ST_WR: begin
        wr_ack_s = bus_ack & bus_req_r;
        fault_s  = abort | timeout_s;
        if (fault_s) begin
          next_state_s = ST_FIN;
        end else if (wr_ack_s) begin
          next_state_s = ST_GAP;
        end else begin
          next_state_s = ST_WR;
        end
      end
      ST_GAP: begin
        fault_s = abort;
        if (fault_s) begin
          next_state_s = ST_FIN;
        end else if (to_wr_r) begin
          next_state_s = ST_WR;
        end else if (rem_r == {CW{1'b0}}) begin
          next_state_s = ST_FIN;
        end else begin
          next_state_s = ST_RD;
        end
      end
      ST_FIN: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Read buffer, GAP direction flag and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r   <= {DW{1'b0}};
      to_wr_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (rd_ack_s && !fault_s) begin
        buf_r <= bus_rdata;
      end
      if (rd_ack_s) begin
        to_wr_r <= 1'b1;
      end else if (wr_ack_s) begin
        to_wr_r <= 1'b0;
      end
      if (start_s) begin
        err_r <= 1'b0;
      end else if (fault_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Registered outputs, computed from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {AW{1'b0}};
      bus_wdata_r <= {DW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      bus_req_r <= is_bus_state(next_state_s);
      busy_r    <= (next_state_s != ST_IDLE);
      done_r    <= (next_state_s == ST_FIN);
      if ((next_state_s == ST_RD) && (state_r != ST_RD)) begin
        bus_we_r   <= 1'b0;
        bus_addr_r <= src_eff_s;
      end else if ((next_state_s == ST_WR) && (state_r != ST_WR)) begin
        bus_we_r    <= 1'b1;
        bus_addr_r  <= dst_r;
        bus_wdata_r <= buf_r;
      end
    end
  end

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign remaining = rem_r;

endmodule
